// File: rtl/apu_sfx_pkg.sv
// Shared definitions for the APU sound-effect scheduler: effect ids,
// per-effect lengths in frames and the scheduler FSM encoding.
package apu_sfx_pkg;

    localparam logic [2:0] SFX_SWORD_HIT   = 3'd0;
    localparam logic [2:0] SFX_PLAYER_HIT  = 3'd1;
    localparam logic [2:0] SFX_SHEEP_EATEN = 3'd2;
    localparam logic [2:0] SFX_DRAGON_GROW = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_t;

    // Effect length in frames (1..32); ids beyond the named effects default to 8.
    function automatic logic [5:0] sfx_len(input logic [2:0] id);
        case (id)
            SFX_SWORD_HIT:   return 6'd16;
            SFX_PLAYER_HIT:  return 6'd32;
            SFX_SHEEP_EATEN: return 6'd24;
            SFX_DRAGON_GROW: return 6'd8;
            default:         return 6'd8;
        endcase
    endfunction

    function automatic logic [4:0] sfx_last(input logic [2:0] id);
        return 5'(sfx_len(id) - 6'd1);
    endfunction

endpackage

// File: rtl/sfx_priority_encoder.sv
// Lowest-set-index encoder over the pending triggers; bit 0 is highest priority.
module sfx_priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         valid
);

    always_comb begin
        idx   = 3'd0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect sequencer: latches event edges, plays one effect at a time with
// fixed-priority preemption, and inserts silent gap frames between effects.
module sfx_scheduler
    import apu_sfx_pkg::*;
#(
    parameter int NUM_SFX     = 4,
    parameter int GAP_FRAMES  = 2,
    parameter int DUCK_ENABLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [NUM_SFX-1:0] event_req,
    output logic               effect_active,
    output logic [2:0]         effect_id,
    output logic [4:0]         effect_frame,
    output logic               effect_start,
    output logic               bgm_mute,
    output logic [NUM_SFX-1:0] pending
);

    localparam logic [NUM_SFX-1:0] ONE = NUM_SFX'(1);

    sfx_state_t         state, state_n;
    logic [NUM_SFX-1:0] req_q, rise, clear;
    logic [2:0]         sel_idx, id_n;
    logic               sel_valid, active_n, start_n;
    logic [4:0]         frame_n;
    logic [7:0]         gap_cnt, gap_n;

    sfx_priority_encoder #(.N(NUM_SFX)) u_prio (
        .req   (pending),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign rise = event_req & ~req_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        id_n     = effect_id;
        frame_n  = effect_frame;
        active_n = effect_active;
        start_n  = 1'b0;
        gap_n    = gap_cnt;
        clear    = '0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_n  = ST_PLAY;
                    id_n     = sel_idx;
                    frame_n  = 5'd0;
                    active_n = 1'b1;
                    start_n  = 1'b1;
                    clear    = ONE << sel_idx;
                end
            end
            ST_PLAY: begin
                // A higher-priority trigger restarts playback and wins over end-of-effect.
                if (sel_valid && (sel_idx < effect_id)) begin
                    id_n     = sel_idx;
                    frame_n  = 5'd0;
                    start_n  = 1'b1;
                    clear    = ONE << sel_idx;
                end else if (frame_tick) begin
                    if (effect_frame == sfx_last(effect_id)) begin
                        state_n  = (GAP_FRAMES == 0) ? ST_IDLE : ST_GAP;
                        id_n     = 3'd0;
                        frame_n  = 5'd0;
                        active_n = 1'b0;
                        gap_n    = 8'd0;
                    end else begin
                        frame_n = effect_frame + 5'd1;
                    end
                end
            end
            ST_GAP: begin
                if (frame_tick) begin
                    if (gap_cnt == 8'(GAP_FRAMES - 1)) begin
                        state_n = ST_IDLE;
                        gap_n   = 8'd0;
                    end else begin
                        gap_n = gap_cnt + 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_q         <= '0;
            pending       <= '0;
            effect_active <= 1'b0;
            effect_id     <= 3'd0;
            effect_frame  <= 5'd0;
            effect_start  <= 1'b0;
            bgm_mute      <= 1'b0;
            gap_cnt       <= 8'd0;
        end else begin
            state         <= state_n;
            req_q         <= event_req;
            pending       <= (pending & ~clear) | rise;
            effect_active <= active_n;
            effect_id     <= id_n;
            effect_frame  <= frame_n;
            effect_start  <= start_n;
            bgm_mute      <= (DUCK_ENABLE != 0) ? active_n : 1'b0;
            gap_cnt       <= gap_n;
        end
    end

endmodule
